// File: rtl/event_stream_decoder_pkg.sv
// Shared types and constants for the EVT2.0 word decoder feeding InputQueue.
package event_stream_decoder_pkg;

  localparam int unsigned SENSOR_WIDTH_DEFAULT  = 640;
  localparam int unsigned SENSOR_HEIGHT_DEFAULT = 480;
  localparam int unsigned TIME_HIGH_BITS        = 28;
  localparam int unsigned TS_LO_BITS            = 6;
  localparam int unsigned COORD_BITS            = 11;
  localparam int unsigned T_BITS                = 32;

  typedef struct packed {
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
    logic                  p;
    logic [T_BITS-1:0]     t;
  } event_t;

  typedef enum logic [3:0] {
    CD_OFF    = 4'h0,
    CD_ON     = 4'h1,
    TIME_HIGH = 4'h8
  } evt_type_e;

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_e;

  // Full timestamp is {time_high, ts_lo}; only the low T_BITS are kept.
  function automatic event_t make_event(input logic [31:0] word,
                                        input logic [TIME_HIGH_BITS-1:0] time_high);
    event_t e;
    logic [TIME_HIGH_BITS+TS_LO_BITS-1:0] full_t;
    full_t = {time_high, word[27:22]};
    e.x = word[21:11];
    e.y = word[10:0];
    e.p = word[28];
    e.t = full_t[T_BITS-1:0];
    return e;
  endfunction

endpackage

// File: rtl/event_stream_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/event_stream_decoder.sv
// Decodes raw EVT2.0 words into event_t records with full timestamps and
// drives the InputQueue push interface; malformed words are dropped and counted.
module event_stream_decoder
  import event_stream_decoder_pkg::*;
#(
  parameter int unsigned SENSOR_WIDTH  = SENSOR_WIDTH_DEFAULT,
  parameter int unsigned SENSOR_HEIGHT = SENSOR_HEIGHT_DEFAULT,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         word_in,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic                stall,
  output event_t              out_event,
  output logic                push,
  output logic                synced,
  output logic [CNT_BITS-1:0] event_count,
  output logic [CNT_BITS-1:0] drop_count,
  output logic [CNT_BITS-1:0] ts_err_count
);

  localparam logic [COORD_BITS-1:0] X_LIM = COORD_BITS'(SENSOR_WIDTH);
  localparam logic [COORD_BITS-1:0] Y_LIM = COORD_BITS'(SENSOR_HEIGHT);

  state_e                    state, state_next;
  evt_type_e                 wtype;
  logic [TIME_HIGH_BITS-1:0] time_high;
  logic                      xfer;
  logic                      in_range;
  logic                      accept_evt;
  logic                      drop_word;
  logic                      ts_err;
  logic                      th_load;
  logic                      clr;

  assign word_ready = rst_n && !(push && stall);
  assign xfer       = word_valid && word_ready;
  assign wtype      = evt_type_e'(word_in[31:28]);
  assign in_range   = (word_in[21:11] < X_LIM) && (word_in[10:0] < Y_LIM);
  assign clr        = !rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= UNSYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (xfer && (wtype == TIME_HIGH)) begin
      state_next = SYNC;
    end
  end

  always_comb begin
    synced     = (state == SYNC);
    accept_evt = 1'b0;
    drop_word  = 1'b0;
    ts_err     = 1'b0;
    th_load    = 1'b0;
    if (xfer) begin
      case (wtype)
        CD_OFF, CD_ON: begin
          if ((state == SYNC) && in_range) begin
            accept_evt = 1'b1;
          end else begin
            drop_word = 1'b1;
          end
        end
        TIME_HIGH: begin
          th_load = 1'b1;
          // A decrease is flagged but still loaded: the sensor counter wrapped.
          ts_err  = (state == SYNC) && (word_in[27:0] < time_high);
        end
        default: drop_word = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      time_high <= '0;
    end else if (th_load) begin
      time_high <= word_in[27:0];
    end
  end

  // Held while stalled with a pending push; otherwise push is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push      <= 1'b0;
      out_event <= '0;
    end else if (!(push && stall)) begin
      push <= accept_evt;
      if (accept_evt) begin
        out_event <= make_event(word_in, time_high);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_BITS)) u_event_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (accept_evt),
    .count (event_count)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_drop_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (drop_word),
    .count (drop_count)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_ts_err_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (ts_err),
    .count (ts_err_count)
  );

endmodule

// File: tb/tb_event_stream_decoder.sv
// Bench for event_stream_decoder: directed table, stall/reset sequences and
// randomized traffic against a behavioural model.
module tb_event_stream_decoder;
  import event_stream_decoder_pkg::*;

  localparam int unsigned CB   = 4;
  localparam int unsigned MAXC = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   word_in;
  logic          word_valid;
  logic          word_ready;
  logic          stall;
  event_t        out_event;
  logic          push;
  logic          synced;
  logic [CB-1:0] event_count;
  logic [CB-1:0] drop_count;
  logic [CB-1:0] ts_err_count;

  always #5 clk = ~clk;

  event_stream_decoder #(
    .SENSOR_WIDTH  (640),
    .SENSOR_HEIGHT (480),
    .CNT_BITS      (CB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .stall        (stall),
    .out_event    (out_event),
    .push         (push),
    .synced       (synced),
    .event_count  (event_count),
    .drop_count   (drop_count),
    .ts_err_count (ts_err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_synced;
  bit          m_push;
  logic [27:0] m_th;
  event_t      m_evt;
  int unsigned m_ev, m_drop, m_ts;

  typedef struct {
    bit          v;
    logic [31:0] w;
    bit          s;
    bit          e_push;
    logic [10:0] e_x;
    logic [10:0] e_y;
    bit          e_p;
    logic [31:0] e_t;
    int unsigned e_ev;
    int unsigned e_drop;
    int unsigned e_ts;
    bit          e_synced;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [31:0] cd_word(bit p, int unsigned ts, int unsigned x, int unsigned y);
    return {3'b000, p, 6'(ts), 11'(x), 11'(y)};
  endfunction

  function automatic logic [31:0] th_word(int unsigned v);
    return {4'h8, 28'(v)};
  endfunction

  function automatic int unsigned sat_inc(int unsigned c);
    return (c < MAXC) ? c + 1 : c;
  endfunction

  function automatic vec_t mk(bit v, logic [31:0] w, bit e_push, int unsigned x, int unsigned y,
                              bit p, logic [31:0] t, int unsigned ev, int unsigned dr,
                              int unsigned ts, bit sy);
    vec_t r;
    r.v = v; r.w = w; r.s = 1'b0; r.e_push = e_push;
    r.e_x = 11'(x); r.e_y = 11'(y); r.e_p = p; r.e_t = t;
    r.e_ev = ev; r.e_drop = dr; r.e_ts = ts; r.e_synced = sy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_push = 0; m_th = '0; m_evt = '0;
    m_ev = 0; m_drop = 0; m_ts = 0;
  endtask

  // Applies the decoder's rules for one clock edge.
  task automatic model_edge(bit r, bit v, logic [31:0] w, bit s);
    logic [3:0]  ty;
    logic [10:0] x, y;
    logic [5:0]  ts;
    logic [27:0] thn;
    logic [63:0] tfull;
    if (!r) begin
      model_reset();
      return;
    end
    if (m_push && s) return;
    m_push = 0;
    if (!v) return;
    ty = w[31:28]; x = w[21:11]; y = w[10:0]; ts = w[27:22]; thn = w[27:0];
    if (ty == 4'h8) begin
      if (m_synced && thn < m_th) m_ts = sat_inc(m_ts);
      m_th = thn;
      m_synced = 1;
    end else if (ty <= 4'h1) begin
      if (m_synced && x < 11'd640 && y < 11'd480) begin
        tfull = 64'(m_th) * 64 + 64'(ts);
        m_evt.x = x;
        m_evt.y = y;
        m_evt.p = ty[0];
        m_evt.t = tfull[31:0];
        m_push = 1;
        m_ev = sat_inc(m_ev);
      end else begin
        m_drop = sat_inc(m_drop);
      end
    end else begin
      m_drop = sat_inc(m_drop);
    end
  endtask

  task automatic step(bit r, bit v, logic [31:0] w, bit s);
    rst_n = r; word_valid = v; word_in = w; stall = s;
    @(negedge clk);
    chk("word_ready", 64'(word_ready), 64'(r && !(m_push && s)));
    @(posedge clk);
    #1;
    model_edge(r, v, w, s);
    chk("push", 64'(push), 64'(m_push));
    chk("synced", 64'(synced), 64'(m_synced));
    chk("event_count", 64'(event_count), 64'(m_ev));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("ts_err_count", 64'(ts_err_count), 64'(m_ts));
    if (m_push) chk("out_event", 64'(out_event), 64'(m_evt));
  endtask

  initial begin
    event_t      exp_e;
    int unsigned sel, tyr;
    logic [31:0] w;

    model_reset();
    tbl[0]  = mk(1, cd_word(1, 3, 5, 7),       0, 0,   0,   0, 32'h0,    0, 1, 0, 0);
    tbl[1]  = mk(1, th_word(28'h10),           0, 0,   0,   0, 32'h0,    0, 1, 0, 1);
    tbl[2]  = mk(1, cd_word(0, 3, 5, 7),       1, 5,   7,   0, 32'h403,  1, 1, 0, 1);
    tbl[3]  = mk(1, cd_word(1, 0, 640, 0),     0, 0,   0,   0, 32'h0,    1, 2, 0, 1);
    tbl[4]  = mk(1, cd_word(1, 0, 0, 480),     0, 0,   0,   0, 32'h0,    1, 3, 0, 1);
    tbl[5]  = mk(1, cd_word(1, 9, 639, 479),   1, 639, 479, 1, 32'h409,  2, 3, 0, 1);
    tbl[6]  = mk(1, 32'h3000_0000,             0, 0,   0,   0, 32'h0,    2, 4, 0, 1);
    tbl[7]  = mk(1, th_word(28'h100),          0, 0,   0,   0, 32'h0,    2, 4, 0, 1);
    tbl[8]  = mk(1, th_word(28'h0FF),          0, 0,   0,   0, 32'h0,    2, 4, 1, 1);
    tbl[9]  = mk(1, cd_word(0, 1, 1, 1),       1, 1,   1,   0, 32'h3FC1, 3, 4, 1, 1);
    tbl[10] = mk(0, 32'h0,                     0, 0,   0,   0, 32'h0,    3, 4, 1, 1);

    step(0, 0, 32'h0, 0);
    chk("reset_push", 64'(push), 64'd0);
    chk("reset_out_event", 64'(out_event), 64'd0);

    for (int i = 0; i < 11; i++) begin
      step(1, tbl[i].v, tbl[i].w, tbl[i].s);
      chk($sformatf("tbl%0d_push", i), 64'(push), 64'(tbl[i].e_push));
      chk($sformatf("tbl%0d_events", i), 64'(event_count), 64'(tbl[i].e_ev));
      chk($sformatf("tbl%0d_drops", i), 64'(drop_count), 64'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_ts_err", i), 64'(ts_err_count), 64'(tbl[i].e_ts));
      chk($sformatf("tbl%0d_synced", i), 64'(synced), 64'(tbl[i].e_synced));
      if (tbl[i].e_push) begin
        exp_e.x = tbl[i].e_x; exp_e.y = tbl[i].e_y;
        exp_e.p = tbl[i].e_p; exp_e.t = tbl[i].e_t;
        chk($sformatf("tbl%0d_event", i), 64'(out_event), 64'(exp_e));
      end
    end

    // Back-to-back events with a three-cycle stall on the first one
    step(0, 0, 32'h0, 0);
    step(1, 1, th_word(28'h20), 0);
    step(1, 1, cd_word(1, 2, 10, 20), 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, cd_word(0, 4, 30, 40), 1);
      chk("stall_ready_low", 64'(word_ready), 64'd0);
      chk("stall_push_held", 64'(push), 64'd1);
      chk("stall_event_x", 64'(out_event.x), 64'd10);
    end
    step(1, 1, cd_word(0, 4, 30, 40), 0);
    chk("after_stall_x", 64'(out_event.x), 64'd30);
    chk("after_stall_count", 64'(event_count), 64'd2);
    step(1, 0, 32'h0, 0);
    chk("pulse_ends", 64'(push), 64'd0);

    // Reset while a stalled push is pending
    step(1, 1, th_word(28'h5), 0);
    step(1, 1, cd_word(1, 1, 3, 3), 0);
    step(0, 1, cd_word(1, 1, 4, 4), 1);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_events", 64'(event_count), 64'd0);
    chk("rst_synced", 64'(synced), 64'd0);
    step(1, 1, cd_word(1, 1, 4, 4), 0);
    chk("post_rst_drop", 64'(drop_count), 64'd1);
    chk("post_rst_nopush", 64'(push), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        w = cd_word(1'($urandom_range(0, 1)), $urandom_range(0, 63),
                    $urandom_range(0, 700), $urandom_range(0, 520));
      end else if (sel <= 7) begin
        w = th_word($urandom_range(0, 63));
      end else begin
        tyr = $urandom_range(2, 15);
        if (tyr == 8) tyr = 9;
        w = {4'(tyr), 28'($urandom)};
      end
      step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 4) != 0), w,
           1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
